// File: rtl/lives_tracker.sv
// lives_tracker
//   Keeps the player's life count for a red-light / green-light game.
//   A free-running prescaler produces a one-clk game tick. On a tick, moving
//   while the light is red costs a life and starts a short invulnerability
//   window. add_life grants a bonus life, saturating at MAX_LIVES.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   reset      asynchronous, active-high reset
//   start      level request to begin or restart a game (sampled every clk)
//   move       player is moving (sampled on tick)
//   red        light is red (sampled on tick)
//   add_life   bonus-life request (sampled on tick)
//   lives      remaining lives (registered)
//   led_n      active-low thermometer, bit i low iff lives > i
//   hit        one-clk pulse on each life loss
//   game_over  high while in OVER
//   state      FSM state code
//
// state | meaning
// IDLE  | waiting for start after reset
// PLAY  | game running, violations cost a life
// GRACE | invulnerable for GRACE_TICKS ticks after a life loss
// OVER  | no lives left, waiting for start
module lives_tracker #(
  parameter int MAX_LIVES   = 3,
  parameter int LW          = 2,
  parameter int TICK_DIV    = 25000000,
  parameter int GRACE_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 move,
  input  logic                 red,
  input  logic                 add_life,
  output logic [LW-1:0]        lives,
  output logic [MAX_LIVES-1:0] led_n,
  output logic                 hit,
  output logic                 game_over,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    GRACE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [LW-1:0] MAX_L      = LW'(MAX_LIVES);
  localparam logic [7:0]    GRACE_LOAD = 8'(GRACE_TICKS);

  state_t        cur_state, nxt_state;
  logic [LW-1:0] nxt_lives;
  logic          nxt_hit;
  logic [PW-1:0] presc, nxt_presc;
  logic [7:0]    grace_cnt, nxt_grace;
  logic          tick;
  logic          violation;
  logic [LW-1:0] lives_inc;

  assign tick      = (presc == PRESC_LAST);
  assign violation = tick && move && red;
  assign lives_inc = (lives >= MAX_L) ? MAX_L : lives + LW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
      lives     <= MAX_L;
      hit       <= 1'b0;
      presc     <= '0;
      grace_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      lives     <= nxt_lives;
      hit       <= nxt_hit;
      presc     <= nxt_presc;
      grace_cnt <= nxt_grace;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    nxt_lives = lives;
    nxt_hit   = 1'b0;
    nxt_presc = tick ? '0 : presc + PW'(1);
    nxt_grace = grace_cnt;

    // start wins over anything else happening in the same cycle
    if (start) begin
      nxt_state = PLAY;
      nxt_lives = MAX_L;
      nxt_presc = '0;
      nxt_grace = '0;
    end else begin
      case (cur_state)
        PLAY: begin
          if (violation) begin
            nxt_hit = 1'b1;
            if (add_life) begin
              // bonus cancels the loss, but the hit still opens a grace window
              nxt_state = GRACE;
              nxt_grace = GRACE_LOAD;
            end else if (lives > LW'(1)) begin
              nxt_lives = lives - LW'(1);
              nxt_state = GRACE;
              nxt_grace = GRACE_LOAD;
            end else begin
              nxt_lives = '0;
              nxt_state = OVER;
            end
          end else if (tick && add_life) begin
            nxt_lives = lives_inc;
          end
        end
        GRACE: begin
          if (tick) begin
            nxt_grace = grace_cnt - 8'd1;
            if (grace_cnt <= 8'd1) begin
              nxt_grace = '0;
              nxt_state = PLAY;
            end
            if (add_life) nxt_lives = lives_inc;
          end
        end
        OVER: begin
          nxt_lives = '0;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    led_n = '1;
    for (int i = 0; i < MAX_LIVES; i++) begin
      led_n[i] = (int'(lives) <= i);
    end
  end

  assign game_over = (cur_state == OVER);
  assign state     = cur_state;

endmodule

// File: tb/tb_lives_tracker.sv
module tb_lives_tracker;

  localparam int MAXL = 3;
  localparam int TDIV = 4;
  localparam int GT   = 2;

  logic            clk;
  logic            reset;
  logic            start, move, red, add_life;
  logic [1:0]      lives;
  logic [MAXL-1:0] led_n;
  logic            hit, game_over;
  logic [1:0]      state;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  // behavioural model
  int m_state = 0, m_lives = MAXL, m_hit = 0, m_cnt = 0, m_grace = 0;
  int m_tick, m_delta, m_new;

  lives_tracker #(.MAX_LIVES(MAXL), .LW(2), .TICK_DIV(TDIV), .GRACE_TICKS(GT)) dut (
    .clk(clk), .reset(reset), .start(start), .move(move), .red(red),
    .add_life(add_life), .lives(lives), .led_n(led_n), .hit(hit),
    .game_over(game_over), .state(state)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game rules in plain integer arithmetic: a tick nets (+bonus - violation)
  // lives, clamped to [0, MAX]; any violation while playing is a hit.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 0; m_lives = MAXL; m_hit = 0; m_cnt = 0; m_grace = 0;
    end else begin
      m_tick = (m_cnt == TDIV - 1);
      m_cnt  = (m_cnt + 1) % TDIV;
      m_hit  = 0;
      if (start) begin
        m_state = 1; m_lives = MAXL; m_cnt = 0; m_grace = 0;
      end else if (m_tick && m_state == 1) begin
        m_delta = (add_life ? 1 : 0) - ((move && red) ? 1 : 0);
        m_new   = m_lives + m_delta;
        if (m_new > MAXL) m_new = MAXL;
        if (m_new < 0) m_new = 0;
        m_lives = m_new;
        if (move && red) begin
          m_hit = 1;
          if (m_lives == 0) m_state = 3;
          else begin m_state = 2; m_grace = GT; end
        end
      end else if (m_tick && m_state == 2) begin
        if (add_life && m_lives < MAXL) m_lives = m_lives + 1;
        m_grace = m_grace - 1;
        if (m_grace == 0) m_state = 1;
      end else if (m_state == 3) begin
        m_lives = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int exp_led;
      exp_led = 0;
      for (int i = 0; i < MAXL; i++) if (!(m_lives > i)) exp_led |= (1 << i);
      check("lives", int'(lives), m_lives);
      check("state", int'(state), m_state);
      check("hit", int'(hit), m_hit);
      check("game_over", int'(game_over), (m_state == 3) ? 1 : 0);
      check("led_n", int'(led_n), exp_led);
    end
  end

  task automatic wait_hit(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hit && n < 60);
    if (!hit) begin
      bad++; total++;
      $display("FAIL %s: timeout waiting for hit, got 0 expected 1", name);
    end
  endtask

  task automatic wait_state(input string name, input int s, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(state) != s && n < 60);
    if (int'(state) != s) begin
      bad++; total++;
      $display("FAIL %s: timeout waiting for state, got %0d expected %0d", name, state, s);
    end
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    int n;
    reset = 1; start = 0; move = 0; red = 0; add_life = 0;
    wait_neg(3);
    reset = 0;
    cmp_en = 1;
    check("rst_state", int'(state), 0);
    check("rst_lives", int'(lives), 3);
    check("rst_led", int'(led_n), 0);
    check("rst_over", int'(game_over), 0);
    check("rst_hit", int'(hit), 0);
    wait_neg(5);
    check("idle_hold", int'(state), 0);

    // start, then constant violation until game over
    do_start();
    check("start_state", int'(state), 1);
    check("start_lives", int'(lives), 3);
    check("start_led", int'(led_n), 0);
    move = 1; red = 1;
    wait_hit("hit1", n);
    check("hit1_latency", n, 4);
    check("hit1_lives", int'(lives), 2);
    check("hit1_state", int'(state), 2);
    wait_hit("hit2", n);
    check("hit2_gap", n, 12);
    check("hit2_lives", int'(lives), 1);
    wait_state("over", 3, n);
    check("over_gap", n, 12);
    check("over_lives", int'(lives), 0);
    check("over_go", int'(game_over), 1);
    check("over_led", int'(led_n), 7);
    check("over_hit", int'(hit), 1);
    move = 0; red = 0; add_life = 1;
    wait_neg(8);
    check("over_ignore_add", int'(lives), 0);
    add_life = 0;

    // bonus life and saturation
    do_start();
    move = 1; red = 1;
    wait_hit("b_hit", n);
    move = 0; red = 0;
    wait_state("b_play", 1, n);
    check("b_lives2", int'(lives), 2);
    add_life = 1;
    wait_neg(4);
    check("bonus_inc", int'(lives), 3);
    wait_neg(4);
    check("bonus_sat", int'(lives), 3);
    add_life = 0;

    // down to one life, then violation + bonus on the same tick
    for (int k = 0; k < 2; k++) begin
      move = 1; red = 1;
      wait_hit("c_hit", n);
      move = 0; red = 0;
      wait_state("c_play", 1, n);
    end
    check("c_lives1", int'(lives), 1);
    move = 1; red = 1; add_life = 1;
    wait_neg(4);
    check("vb_lives", int'(lives), 1);
    check("vb_hit", int'(hit), 1);
    check("vb_state", int'(state), 2);
    check("vb_go", int'(game_over), 0);
    move = 0; red = 0; add_life = 0;
    wait_state("d_play", 1, n);
    add_life = 1;
    wait_neg(4);
    add_life = 0;
    check("d_lives2", int'(lives), 2);

    // start coincident with a violation tick
    move = 1; red = 1;
    wait_neg(3);
    start = 1;
    @(negedge clk);
    start = 0;
    check("sv_lives", int'(lives), 3);
    check("sv_state", int'(state), 1);
    check("sv_hit", int'(hit), 0);
    move = 0; red = 0;

    // asynchronous reset while in GRACE with hit high
    do_start();
    move = 1; red = 1;
    wait_hit("r_hit", n);
    check("r_pre_state", int'(state), 2);
    #2 reset = 1;
    #1;
    check("async_state", int'(state), 0);
    check("async_lives", int'(lives), 3);
    check("async_hit", int'(hit), 0);
    #1 reset = 0;
    wait_neg(10);
    check("post_rst_idle", int'(state), 0);
    move = 0; red = 0;
    wait_neg(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lives_tracker.md
LIVES_TRACKER -- requirements
Module: lives_tracker

Interface
REQ-001 The block SHALL have parameter MAX_LIVES, default 3, meaning lives loaded at game start; legal range 1..(2**LW)-1.
REQ-002 The block SHALL have parameter LW, default 2, meaning width of the lives count.
REQ-003 The block SHALL have parameter TICK_DIV, default 25000000, meaning clk cycles per game tick; legal range >=2.
REQ-004 The block SHALL have parameter GRACE_TICKS, default 2, meaning ticks of invulnerability after a life loss; legal range 1..255.
REQ-005 The block SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning the asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1, meaning a level request to begin or restart a game, sampled every clk.
REQ-008 The block SHALL have port move, input, 1, meaning the player is moving, sampled on tick only.
REQ-009 The block SHALL have port red, input, 1, meaning the light is red, sampled on tick only.
REQ-010 The block SHALL have port add_life, input, 1, meaning a bonus-life request, sampled on tick only.
REQ-011 The block SHALL have port lives, output, LW, meaning remaining lives, registered.
REQ-012 The block SHALL have port led_n, output, MAX_LIVES, meaning an active-low thermometer where bit i = 0 iff lives > i.
REQ-013 The block SHALL have port hit, output, 1, meaning a one-clk pulse on each life loss.
REQ-014 The block SHALL have port game_over, output, 1, meaning high while in state OVER.
REQ-015 The block SHALL have port state, output, 2, meaning FSM state: IDLE=0, PLAY=1, GRACE=2, OVER=3.

Function
REQ-016 The block SHALL keep a prescaler counting 0..TICK_DIV-1 that wraps to 0, with internal tick asserted for one clk when the count equals TICK_DIV-1; no derived clocks.
REQ-017 The block SHALL treat a violation as tick && move && red.
REQ-018 In IDLE, start=1 SHALL cause, on the next edge: state PLAY, lives=MAX_LIVES, prescaler=0, grace counter=0.
REQ-019 In PLAY, a violation without add_life SHALL decrement lives, pulse hit, and go to GRACE with grace counter=GRACE_TICKS if the pre-decrement lives>1, or go to OVER with lives=0 otherwise.
REQ-020 In GRACE, violations SHALL be ignored (no hit, no decrement); each tick decrements the grace counter, and the tick that brings it to 0 returns state to PLAY.
REQ-021 In PLAY or GRACE, a tick with add_life=1 SHALL increment lives, saturating at MAX_LIVES.
REQ-022 In PLAY, a violation and add_life on the same tick SHALL leave lives unchanged, pulse hit, and enter GRACE (never OVER).
REQ-023 In OVER, the block SHALL hold lives=0 and game_over=1, and ignore move, red and add_life; start=1 restarts per REQ-018.
REQ-024 start=1 in PLAY or GRACE SHALL restart per REQ-018 and take priority over any same-cycle violation or add_life; hit stays 0 that cycle.
REQ-025 All lives arithmetic SHALL be LW-bit unsigned, with no wrap below 0 or above MAX_LIVES.
REQ-026 The led_n and game_over outputs SHALL be combinational decodes of registered lives and state.

Reset
REQ-027 reset=1 SHALL, asynchronously, force state=IDLE, lives=MAX_LIVES, hit=0, prescaler=0, and grace counter=0, giving game_over=0 and led_n all-zero.
REQ-028 Reset asserted mid-game (including in GRACE or OVER) SHALL abandon the game, and the block SHALL then wait in IDLE for start.

Verification
REQ-029 The bench SHALL use TICK_DIV=4, GRACE_TICKS=2, MAX_LIVES=3, LW=2.
REQ-030 Reset then start -> state=1, lives=3, led_n=000, ticks every 4 clk.
REQ-031 move=red=1 held in PLAY -> hit on tick 1, lives=2, state=2; ticks 2-3 no hit; tick 4 hit, lives=1; after 2 grace ticks, next tick -> lives=0, state=3, game_over=1, led_n=111.
REQ-032 Lives=2 in PLAY, add_life=1 on a tick without violation -> lives=3; add_life again -> lives stays 3.
REQ-033 Lives=1 in PLAY, violation and add_life on the same tick -> lives=1, hit=1, state=2, game_over=0.
REQ-034 Violation tick coincident with start=1 in PLAY at lives=2 -> lives=3, state=1, hit=0.
REQ-035 Reset pulsed between clk edges while in GRACE -> outputs change immediately to state=0, lives=3, hit=0, without waiting for a clk edge.
